hs_npu_job_dispatcher: RTL and testbench

Parametrised job front-end for the NPU core: buffers up to DEPTH layer-job descriptors in a FIFO and checks each job's matrix dimensions before launch. It issues one job at a time to the memory ordering unit over a valid/ready handshake and waits for completion with an optional timeout watchdog. It then reports a per-job exit code and a sticky interrupt. It sits between the CSR block (descriptor pushes, IRQ clear) and the memory ordering unit / datapath (job fields, start, finished).

---
 rtl/hs_npu_job_dispatcher.sv | 225 ++++++++++++++++++++++
 tb/tb_hs_npu_job_dispatcher.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_npu_job_dispatcher.sv
// NPU job front-end: descriptor FIFO, dimension check, valid/ready issue to the
// memory ordering unit, completion wait with optional watchdog, exit code + IRQ.
module hs_npu_job_dispatcher #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DIM_W     = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_DIM   = 1024,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [DIM_W-1:0]        in_rows_i,
  input  logic [DIM_W-1:0]        in_cols_i,
  input  logic [DIM_W-1:0]        w_rows_i,
  input  logic [DIM_W-1:0]        w_cols_i,
  input  logic [ADDR_W-1:0]       base_addr_i,
  input  logic [ADDR_W-1:0]       result_addr_i,
  input  logic [5:0]              flags_i,
  input  logic [4:0]              shift_i,
  input  logic [TIMEOUT_W-1:0]    timeout_i,
  input  logic                    irq_clr_i,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    overflow_o,
  output logic                    mou_valid_o,
  input  logic                    mou_ready_i,
  input  logic                    finished_i,
  output logic [DIM_W-1:0]        job_in_rows_o,
  output logic [DIM_W-1:0]        job_in_cols_o,
  output logic [DIM_W-1:0]        job_w_rows_o,
  output logic [DIM_W-1:0]        job_w_cols_o,
  output logic [ADDR_W-1:0]       job_base_addr_o,
  output logic [ADDR_W-1:0]       job_result_addr_o,
  output logic [5:0]              job_flags_o,
  output logic [4:0]              job_shift_o,
  output logic [TIMEOUT_W-1:0]    job_timeout_o,
  output logic                    busy_o,
  output logic                    exit_valid_o,
  output logic [2:0]              exit_code_o,
  output logic                    irq_o,
  output logic [15:0]             jobs_done_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  localparam logic [2:0] CodeNone     = 3'd0;
  localparam logic [2:0] CodeOk       = 3'd1;
  localparam logic [2:0] CodeMismatch = 3'd2;
  localparam logic [2:0] CodeZero     = 3'd3;
  localparam logic [2:0] CodeTimeout  = 3'd4;
  localparam logic [2:0] CodeTooLarge = 3'd5;

  typedef struct packed {
    logic [DIM_W-1:0]     in_rows;
    logic [DIM_W-1:0]     in_cols;
    logic [DIM_W-1:0]     w_rows;
    logic [DIM_W-1:0]     w_cols;
    logic [ADDR_W-1:0]    base_addr;
    logic [ADDR_W-1:0]    result_addr;
    logic [5:0]           flags;
    logic [4:0]           shift;
    logic [TIMEOUT_W-1:0] timeout;
  } desc_t;

  typedef enum logic [2:0] {StIdle, StCheck, StIssue, StRun, StDone} state_e;

  state_e              state_q;
  desc_t               mem_q [DEPTH];
  desc_t               push_desc;
  desc_t               job_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       count_q;
  logic                overflow_q;
  logic                full;
  logic                pop;
  logic                push_ok;
  logic                mou_valid_q;
  logic                exit_valid_q;
  logic [2:0]          exit_code_q;
  logic                irq_q;
  logic [15:0]         jobs_done_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic [2:0]          chk_code;
  logic [2:0]          done_code;
  logic [DIM_W-1:0]    max_dim;

  assign max_dim = DIM_W'(MAX_DIM);

  assign push_desc = '{in_rows: in_rows_i, in_cols: in_cols_i, w_rows: w_rows_i,
                       w_cols: w_cols_i, base_addr: base_addr_i,
                       result_addr: result_addr_i, flags: flags_i, shift: shift_i,
                       timeout: timeout_i};

  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign pop     = (state_q == StIdle) && (count_q != '0);
  // A push into a full queue still fits when the head leaves in the same cycle.
  assign push_ok = push_i && (!full || pop);

  // Descriptor storage; pointers handle the flush, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_desc;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PtrW+1)'(push_ok) - (PtrW+1)'(pop);
      if (push_i && full && !pop) overflow_q <= 1'b1;
      else if (irq_clr_i)         overflow_q <= 1'b0;
    end
  end

  // Dimension checks in priority order: zero, too large, inner mismatch.
  always_comb begin
    chk_code = CodeNone;
    if (job_q.in_rows == '0 || job_q.in_cols == '0 ||
        job_q.w_rows == '0 || job_q.w_cols == '0) begin
      chk_code = CodeZero;
    end else if (job_q.in_rows > max_dim || job_q.in_cols > max_dim ||
                 job_q.w_rows > max_dim || job_q.w_cols > max_dim) begin
      chk_code = CodeTooLarge;
    end else if (job_q.in_cols != job_q.w_rows) begin
      chk_code = CodeMismatch;
    end
  end

  // Exit code to report on the next edge; non-zero means the job ends now.
  always_comb begin
    done_code = CodeNone;
    case (state_q)
      StCheck: done_code = chk_code;
      StRun: begin
        if (finished_i) begin
          done_code = CodeOk;
        end else if (job_q.timeout != '0 &&
                     wd_q == job_q.timeout - TIMEOUT_W'(1)) begin
          done_code = CodeTimeout;
        end
      end
      default: done_code = CodeNone;
    endcase
  end

  // Job sequencing FSM with registered handshake and exit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      job_q        <= '0;
      mou_valid_q  <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= CodeNone;
      irq_q        <= 1'b0;
      jobs_done_q  <= '0;
      wd_q         <= '0;
    end else begin
      exit_valid_q <= 1'b0;
      if (irq_clr_i) irq_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pop) begin
            job_q   <= mem_q[rd_ptr_q];
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (chk_code == CodeNone) begin
            mou_valid_q <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (mou_ready_i) begin
            mou_valid_q <= 1'b0;
            wd_q        <= '0;
            state_q     <= StRun;
          end
        end
        StRun: begin
          wd_q <= wd_q + 1'b1;
        end
        StDone: begin
          // Completion set takes priority over a coincident clear.
          irq_q   <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (done_code != CodeNone) begin
        state_q      <= StDone;
        exit_valid_q <= 1'b1;
        exit_code_q  <= done_code;
        irq_q        <= 1'b1;
        jobs_done_q  <= jobs_done_q + 16'd1;
      end
    end
  end

  assign count_o           = count_q;
  assign full_o            = full;
  assign overflow_o        = overflow_q;
  assign mou_valid_o       = mou_valid_q;
  assign busy_o            = (state_q != StIdle);
  assign exit_valid_o      = exit_valid_q;
  assign exit_code_o       = exit_code_q;
  assign irq_o             = irq_q;
  assign jobs_done_o       = jobs_done_q;
  assign job_in_rows_o     = job_q.in_rows;
  assign job_in_cols_o     = job_q.in_cols;
  assign job_w_rows_o      = job_q.w_rows;
  assign job_w_cols_o      = job_q.w_cols;
  assign job_base_addr_o   = job_q.base_addr;
  assign job_result_addr_o = job_q.result_addr;
  assign job_flags_o       = job_q.flags;
  assign job_shift_o       = job_q.shift;
  assign job_timeout_o     = job_q.timeout;

endmodule

// File: tb/tb_hs_npu_job_dispatcher.sv
// Directed bench for hs_npu_job_dispatcher with hand-computed expectations.
module tb_hs_npu_job_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_i = 1'b0;
  logic [31:0] in_rows_i = '0, in_cols_i = '0, w_rows_i = '0, w_cols_i = '0;
  logic [31:0] base_addr_i = '0, result_addr_i = '0;
  logic [5:0]  flags_i = '0;
  logic [4:0]  shift_i = '0;
  logic [15:0] timeout_i = '0;
  logic        irq_clr_i = 1'b0;
  logic        mou_ready_i = 1'b0;
  logic        finished_i = 1'b0;
  logic [2:0]  count_o;
  logic        full_o, overflow_o, mou_valid_o, busy_o, exit_valid_o, irq_o;
  logic [31:0] job_in_rows_o, job_in_cols_o, job_w_rows_o, job_w_cols_o;
  logic [31:0] job_base_addr_o, job_result_addr_o;
  logic [5:0]  job_flags_o;
  logic [4:0]  job_shift_o;
  logic [15:0] job_timeout_o;
  logic [2:0]  exit_code_o;
  logic [15:0] jobs_done_o;

  int n_checks = 0;
  int n_pass   = 0;
  int exit_cnt = 0;
  int mv_cnt   = 0;

  hs_npu_job_dispatcher dut (
    .clk              (clk),
    .rst              (rst),
    .push_i           (push_i),
    .in_rows_i        (in_rows_i),
    .in_cols_i        (in_cols_i),
    .w_rows_i         (w_rows_i),
    .w_cols_i         (w_cols_i),
    .base_addr_i      (base_addr_i),
    .result_addr_i    (result_addr_i),
    .flags_i          (flags_i),
    .shift_i          (shift_i),
    .timeout_i        (timeout_i),
    .irq_clr_i        (irq_clr_i),
    .count_o          (count_o),
    .full_o           (full_o),
    .overflow_o       (overflow_o),
    .mou_valid_o      (mou_valid_o),
    .mou_ready_i      (mou_ready_i),
    .finished_i       (finished_i),
    .job_in_rows_o    (job_in_rows_o),
    .job_in_cols_o    (job_in_cols_o),
    .job_w_rows_o     (job_w_rows_o),
    .job_w_cols_o     (job_w_cols_o),
    .job_base_addr_o  (job_base_addr_o),
    .job_result_addr_o(job_result_addr_o),
    .job_flags_o      (job_flags_o),
    .job_shift_o      (job_shift_o),
    .job_timeout_o    (job_timeout_o),
    .busy_o           (busy_o),
    .exit_valid_o     (exit_valid_o),
    .exit_code_o      (exit_code_o),
    .irq_o            (irq_o),
    .jobs_done_o      (jobs_done_o)
  );

  always #5 clk = ~clk;

  // Count exit pulses and issue-request cycles mid-cycle.
  always @(negedge clk) begin
    if (exit_valid_o) exit_cnt <= exit_cnt + 1;
    if (mou_valid_o)  mv_cnt   <= mv_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [31:0] ir, input logic [31:0] ic, input logic [31:0] wr,
                          input logic [31:0] wc, input logic [31:0] ra, input logic [15:0] to);
    in_rows_i = ir; in_cols_i = ic; w_rows_i = wr; w_cols_i = wc;
    result_addr_i = ra; timeout_i = to;
    base_addr_i = 32'hA000_0000; flags_i = 6'b10_0101; shift_i = 5'd3;
    push_i = 1'b1;
    tick();
    push_i = 1'b0;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!mou_valid_o && n < 20) begin
      tick();
      n++;
    end
    check("issue_seen", mou_valid_o, 1);
  endtask

  task automatic accept();
    mou_ready_i = 1'b1;
    tick();
    mou_ready_i = 1'b0;
  endtask

  task automatic finish_job();
    finished_i = 1'b1;
    tick();
    finished_i = 1'b0;
  endtask

  // Pushes a job that must fail CHECK and verifies its exit three cycles on.
  task automatic run_err(input string tag, input logic [31:0] ir, input logic [31:0] ic,
                         input logic [31:0] wr, input logic [31:0] wc, input logic [2:0] code);
    int mv0 = mv_cnt;
    push_job(ir, ic, wr, wc, 32'h3000, 16'd0);
    tick();
    tick();
    check({tag, "_exit_valid"}, exit_valid_o, 1);
    check({tag, "_code"}, exit_code_o, code);
    tick();
    check({tag, "_no_issue"}, mv_cnt, mv0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int e0, n, vcnt, stable;
    tick();
    tick();
    rst = 1'b0;
    check("rst_count", count_o, 0);
    check("rst_full", full_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_mou_valid", mou_valid_o, 0);
    check("rst_exit_code", exit_code_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_jobs_done", jobs_done_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_job_rows", job_in_rows_o, 0);

    // Legal job, accepted immediately, finished 10 cycles after transfer.
    push_job(4, 8, 8, 4, 32'h1000, 16'd0);
    check("legal_count1", count_o, 1);
    tick();
    check("legal_check_busy", busy_o, 1);
    check("legal_job_rows", job_in_rows_o, 4);
    check("legal_job_wcols", job_w_cols_o, 4);
    check("legal_job_flags", job_flags_o, 6'b10_0101);
    check("legal_count0", count_o, 0);
    tick();
    check("legal_valid", mou_valid_o, 1);
    accept();
    check("legal_valid_drop", mou_valid_o, 0);
    repeat (9) tick();
    check("legal_no_exit_yet", exit_cnt, 0);
    finish_job();
    check("legal_exit_valid", exit_valid_o, 1);
    check("legal_code", exit_code_o, 1);
    check("legal_irq", irq_o, 1);
    check("legal_jobs_done", jobs_done_o, 1);
    tick();
    check("legal_pulse_once", exit_valid_o, 0);
    check("legal_exit_cnt", exit_cnt, 1);
    check("legal_idle", busy_o, 0);

    // Handshake stall: ready low for five cycles.
    push_job(4, 8, 8, 4, 32'h2000, 16'd0);
    tick();
    tick();
    vcnt = 0;
    stable = 1;
    for (int i = 0; i < 6; i++) begin
      if (mou_valid_o) vcnt++;
      if (job_result_addr_o != 32'h2000 || job_in_cols_o != 8) stable = 0;
      if (i == 5) mou_ready_i = 1'b1;
      tick();
    end
    mou_ready_i = 1'b0;
    check("stall_valid_cycles", vcnt, 6);
    check("stall_job_stable", stable, 1);
    check("stall_valid_drop", mou_valid_o, 0);
    finish_job();
    check("stall_code", exit_code_o, 1);
    check("stall_jobs_done", jobs_done_o, 2);
    tick();
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    check("irq_clear", irq_o, 0);

    // Descriptor errors.
    run_err("err_mismatch", 4, 8, 7, 4, 3'd2);
    run_err("err_zero", 4, 8, 8, 0, 3'd3);
    run_err("err_large", 1025, 8, 8, 4, 3'd5);
    check("err_jobs_done", jobs_done_o, 5);

    // Watchdog expiry 20 cycles after entering RUN.
    push_job(4, 8, 8, 4, 32'h4000, 16'd20);
    wait_issue();
    accept();
    n = 0;
    while (!exit_valid_o && n < 100) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, 20);
    check("tmo_code", exit_code_o, 4);
    tick();

    // Watchdog disabled: no exit in 1000 cycles.
    push_job(4, 8, 8, 4, 32'h5000, 16'd0);
    wait_issue();
    accept();
    e0 = exit_cnt;
    repeat (1000) tick();
    check("tmo0_no_exit", exit_cnt, e0);
    check("tmo0_busy", busy_o, 1);
    finish_job();
    check("tmo0_code", exit_code_o, 1);
    tick();
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    check("irq_clear2", irq_o, 0);

    // finished_i coinciding with timeout wins; clear during DONE loses.
    push_job(4, 8, 8, 4, 32'h6000, 16'd5);
    wait_issue();
    accept();
    repeat (4) tick();
    finish_job();
    check("tie_code", exit_code_o, 1);
    check("tie_exit_valid", exit_valid_o, 1);
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    check("clr_in_done_irq", irq_o, 1);
    check("tie_jobs_done", jobs_done_o, 8);

    // Reset during RUN with one job queued behind it.
    push_job(4, 8, 8, 4, 32'h7000, 16'd0);
    wait_issue();
    accept();
    push_job(4, 8, 8, 4, 32'h7100, 16'd0);
    e0 = exit_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rrun_busy", busy_o, 0);
    check("rrun_count", count_o, 0);
    check("rrun_mou_valid", mou_valid_o, 0);
    check("rrun_exit_code", exit_code_o, 0);
    check("rrun_irq", irq_o, 0);
    check("rrun_jobs_done", jobs_done_o, 0);
    check("rrun_job_addr", job_result_addr_o, 0);
    tick();
    check("rrun_no_pulse", exit_cnt, e0);
    check("rrun_still_idle", busy_o, 0);

    // Queue fill while a job runs: DEPTH+1 pushes, last one dropped.
    push_job(4, 8, 8, 4, 32'h100, 16'd0);
    wait_issue();
    accept();
    for (int k = 0; k < 5; k++) push_job(4, 8, 8, 4, 32'h200 + 32'h100 * k, 16'd0);
    check("q_count", count_o, 4);
    check("q_full", full_o, 1);
    check("q_overflow", overflow_o, 1);
    finish_job();
    check("q_first_addr", job_result_addr_o, 32'h100);
    check("q_first_code", exit_code_o, 1);
    for (int k = 0; k < 4; k++) begin
      wait_issue();
      check("q_order_addr", job_result_addr_o, 32'h200 + 32'h100 * k);
      accept();
      finish_job();
      check("q_exit_valid", exit_valid_o, 1);
      check("q_code", exit_code_o, 1);
    end
    check("q_jobs_done", jobs_done_o, 5);
    check("q_empty", count_o, 0);
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    check("q_overflow_clr", overflow_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
